// File: rtl/psec6_readout_seq.sv
// Readout sequencer for the PSEC6 channel counters. It steps the channel select through every counter,
// captures each word and splits it into bytes (MSB first) for a show-ahead byte FIFO drained by the SPI slave.
module psec6_readout_seq #(
    parameter int NUM_REGS   = 6,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int SETTLE     = 2
) (
    input  logic                          spi_clk,
    input  logic                          rst,
    input  logic                          inst_readout,
    input  logic                          inst_rst,
    input  logic [DATA_W-1:0]             chan_data,
    input  logic                          rd_req,
    output logic [2:0]                    select_reg,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          underflow
);

    localparam int BYTES  = DATA_W / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int SET_W  = $clog2(SETTLE + 1);
    localparam int BYTE_W = $clog2(BYTES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        CAPTURE = 2'd2,
        PUSH    = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [SET_W-1:0]    settle_r, settle_s;
    logic [2:0]          idx_r, idx_s;
    logic [2:0]          sel_r, sel_s;
    logic                busy_r, busy_s;
    logic [DATA_W-1:0]   shreg_r, shreg_s;
    logic [BYTE_W-1:0]   byte_r, byte_s;

    logic [7:0]          mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wptr_r;
    logic [PTR_W-1:0]    rptr_r;
    logic [CNT_W-1:0]    count_r;
    logic                underflow_r;

    logic                empty_s;
    logic                full_s;
    logic                pop_s;
    logic                push_s;
    logic [7:0]          push_byte_s;

    assign empty_s     = (count_r == CNT_W'(0));
    assign full_s      = (count_r == CNT_W'(FIFO_DEPTH));
    assign pop_s       = rd_req && !empty_s;
    assign push_byte_s = shreg_r[DATA_W-1 -: 8];

    // FSM and datapath state registers; inst_rst overrides everything at the edge
    always_ff @(posedge spi_clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            settle_r <= SET_W'(0);
            idx_r    <= 3'd0;
            sel_r    <= 3'd0;
            busy_r   <= 1'b0;
            shreg_r  <= {DATA_W{1'b0}};
            byte_r   <= BYTE_W'(0);
        end else if (inst_rst) begin
            state_r  <= IDLE;
            settle_r <= SET_W'(0);
            idx_r    <= 3'd0;
            sel_r    <= 3'd0;
            busy_r   <= 1'b0;
            shreg_r  <= {DATA_W{1'b0}};
            byte_r   <= BYTE_W'(0);
        end else begin
            state_r  <= state_s;
            settle_r <= settle_s;
            idx_r    <= idx_s;
            sel_r    <= sel_s;
            busy_r   <= busy_s;
            shreg_r  <= shreg_s;
            byte_r   <= byte_s;
        end
    end

    // Next-state logic; a full FIFO only accepts a push when a pop frees a slot in the same cycle
    always_comb begin
        state_s  = state_r;
        settle_s = settle_r;
        idx_s    = idx_r;
        sel_s    = sel_r;
        busy_s   = busy_r;
        shreg_s  = shreg_r;
        byte_s   = byte_r;
        push_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (inst_readout) begin
                    state_s  = SELECT;
                    idx_s    = 3'd0;
                    sel_s    = 3'd0;
                    busy_s   = 1'b1;
                    settle_s = SET_W'(SETTLE);
                end else begin
                    busy_s = 1'b0;
                end
            end
            SELECT: begin
                if (settle_r <= SET_W'(1)) begin
                    state_s = CAPTURE;
                end else begin
                    settle_s = settle_r - SET_W'(1);
                end
            end
            CAPTURE: begin
                shreg_s = chan_data;
                byte_s  = BYTE_W'(BYTES);
                state_s = PUSH;
            end
            PUSH: begin
                if (!full_s || pop_s) begin
                    push_s  = 1'b1;
                    shreg_s = shreg_r << 32'd8;
                    if (byte_r <= BYTE_W'(1)) begin
                        if (idx_r < 3'(NUM_REGS - 1)) begin
                            idx_s    = idx_r + 3'd1;
                            sel_s    = idx_r + 3'd1;
                            settle_s = SET_W'(SETTLE);
                            state_s  = SELECT;
                        end else begin
                            state_s = IDLE;
                            busy_s  = 1'b0;
                        end
                    end else begin
                        byte_s = byte_r - BYTE_W'(1);
                    end
                end else begin
                    push_s = 1'b0;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // FIFO storage; stale contents are harmless because the pointers define what is valid
    always_ff @(posedge spi_clk) begin
        if (push_s && !inst_rst) begin
            mem_r[wptr_r] <= push_byte_s;
        end
    end

    // FIFO pointers, occupancy and sticky underflow flag
    always_ff @(posedge spi_clk or posedge rst) begin
        if (rst) begin
            wptr_r      <= PTR_W'(0);
            rptr_r      <= PTR_W'(0);
            count_r     <= CNT_W'(0);
            underflow_r <= 1'b0;
        end else if (inst_rst) begin
            wptr_r      <= PTR_W'(0);
            rptr_r      <= PTR_W'(0);
            count_r     <= CNT_W'(0);
            underflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (rd_req && empty_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign select_reg = sel_r;
    assign busy       = busy_r;
    assign fifo_count = count_r;
    assign rd_valid   = !empty_s;
    assign rd_data    = empty_s ? 8'h00 : mem_r[rptr_r];
    assign underflow  = underflow_r;

endmodule
